rob_entry_file: RTL



---
 rtl/rob_pkg.sv | 20 ++
 rtl/rob_entry_file_if.sv | 34 +++
 rtl/rob_entry_wsel.sv | 31 +++
 rtl/rob_entry_file.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared constants and types for the reorder-buffer entry file:
// default widths, writeback port-select encoding and depth helper.
package rob_pkg;

  localparam int ROB_ADDR_WIDTH = 3;
  localparam int ROB_DATA_WIDTH = 16;
  localparam int ROB_DEST_WIDTH = 3;
  localparam int ROB_DEPTH      = 1 << ROB_ADDR_WIDTH;

  typedef logic [1:0] wb_sel_t;

  localparam wb_sel_t WB_SEL_A = 2'b00;
  localparam wb_sel_t WB_SEL_B = 2'b01;
  localparam wb_sel_t WB_SEL_C = 2'b10;

  function automatic int rob_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/rob_entry_file_if.sv
// Allocate / writeback / commit bundle of the reorder-buffer entry file.
// master = instruction-side driver, slave = rob_entry_file.
interface rob_entry_file_if
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROB_DATA_WIDTH,
  parameter int DEST_WIDTH = ROB_DEST_WIDTH
);
  logic                  alloc_valid;
  logic [DEST_WIDTH-1:0] alloc_dest;
  logic                  alloc_ready;
  logic [ADDR_WIDTH-1:0] alloc_tag;
  logic                  we_a, we_b, we_c;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c;
  logic [DATA_WIDTH-1:0] data_a, data_b, data_c;
  logic                  flush;
  logic                  commit_valid;
  logic [DEST_WIDTH-1:0] commit_dest;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output alloc_valid, alloc_dest, we_a, we_b, we_c, addr_a, addr_b, addr_c,
           data_a, data_b, data_c, flush,
    input  alloc_ready, alloc_tag, commit_valid, commit_dest, commit_data, count
  );

  modport slave (
    input  alloc_valid, alloc_dest, we_a, we_b, we_c, addr_a, addr_b, addr_c,
           data_a, data_b, data_c, flush,
    output alloc_ready, alloc_tag, commit_valid, commit_dest, commit_data, count
  );
endinterface

// File: rtl/rob_entry_wsel.sv
// Per-entry writeback port selection: detects which ports target this entry
// and picks the winner with fixed priority a > b > c.
module rob_entry_wsel
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH
) (
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic                  we_c,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_c,
  input  logic [ADDR_WIDTH-1:0] entry_idx,
  output logic                  entry_we,
  output wb_sel_t               sel
);
  logic hit_a, hit_b, hit_c;

  assign hit_a    = we_a && (addr_a == entry_idx);
  assign hit_b    = we_b && (addr_b == entry_idx);
  assign hit_c    = we_c && (addr_c == entry_idx);
  assign entry_we = hit_a || hit_b || hit_c;

  always_comb begin
    sel = WB_SEL_A;
    if (hit_a)      sel = WB_SEL_A;
    else if (hit_b) sel = WB_SEL_B;
    else if (hit_c) sel = WB_SEL_C;
  end
endmodule

// File: rtl/rob_entry_file.sv
// Circular reorder-buffer entry store: in-order allocate/retire, three
// out-of-order writeback ports. Optional ROB_WB_BYPASS_EN: same-edge commit of head writeback.
module rob_entry_file
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROB_DATA_WIDTH,
  parameter int DEST_WIDTH = ROB_DEST_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  rob_entry_file_if.slave  bus
);
  localparam int DEPTH = rob_depth(ADDR_WIDTH);
  typedef logic [ADDR_WIDTH-1:0] ptr_t;

  logic [DEPTH-1:0]      valid_vec, done_vec, entry_we, wb_fire, alloc_hit;
  logic [DEST_WIDTH-1:0] dest_arr [DEPTH];
  logic [DATA_WIDTH-1:0] data_arr [DEPTH];
  logic [DATA_WIDTH-1:0] wb_data  [DEPTH];

  ptr_t                  head_reg, tail_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  commit_valid_reg;
  logic [DEST_WIDTH-1:0] commit_dest_reg;
  logic [DATA_WIDTH-1:0] commit_data_reg;

  logic alloc_ready, alloc_fire, commit_fire, bypass_hit;
  logic [DATA_WIDTH-1:0] commit_data_next;

  // Readiness looks at the registered count only, so a full buffer never
  // admits an allocation even when an entry retires on the same edge.
  assign alloc_ready = count_reg < (ADDR_WIDTH+1)'(DEPTH);
  assign alloc_fire  = bus.alloc_valid && alloc_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    wb_sel_t               sel;
    logic                  valid_reg, done_reg;
    logic [DEST_WIDTH-1:0] dest_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    rob_entry_wsel #(.ADDR_WIDTH(ADDR_WIDTH)) u_wsel (
      .we_a      (bus.we_a),
      .we_b      (bus.we_b),
      .we_c      (bus.we_c),
      .addr_a    (bus.addr_a),
      .addr_b    (bus.addr_b),
      .addr_c    (bus.addr_c),
      .entry_idx (ptr_t'(gi)),
      .entry_we  (entry_we[gi]),
      .sel       (sel)
    );

    assign wb_data[gi]   = (sel == WB_SEL_B) ? bus.data_b :
                           (sel == WB_SEL_C) ? bus.data_c : bus.data_a;
    assign alloc_hit[gi] = alloc_fire && (tail_reg == ptr_t'(gi));
    // Writes only land on entries live before the edge; a same-cycle allocation wins.
    assign wb_fire[gi]   = entry_we[gi] && valid_reg && !alloc_hit[gi];

    assign valid_vec[gi] = valid_reg;
    assign done_vec[gi]  = done_reg;
    assign dest_arr[gi]  = dest_reg;
    assign data_arr[gi]  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        done_reg  <= 1'b0;
        dest_reg  <= '0;
        data_reg  <= '0;
      end else if (bus.flush) begin
        valid_reg <= 1'b0;
        done_reg  <= 1'b0;
      end else begin
        if (commit_fire && (head_reg == ptr_t'(gi))) valid_reg <= 1'b0;
        if (alloc_hit[gi]) begin
          valid_reg <= 1'b1;
          done_reg  <= 1'b0;
          dest_reg  <= bus.alloc_dest;
        end else if (wb_fire[gi]) begin
          done_reg  <= 1'b1;
          data_reg  <= wb_data[gi];
        end
      end
    end
  end

`ifdef ROB_WB_BYPASS_EN
  assign bypass_hit = valid_vec[head_reg] && !done_vec[head_reg] && wb_fire[head_reg];
`else
  assign bypass_hit = 1'b0;
`endif

  assign commit_fire      = (count_reg != '0) && valid_vec[head_reg] &&
                            (done_vec[head_reg] || bypass_hit);
  assign commit_data_next = bypass_hit ? wb_data[head_reg] : data_arr[head_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      commit_valid_reg <= 1'b0;
      commit_dest_reg  <= '0;
      commit_data_reg  <= '0;
    end else if (bus.flush) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      commit_valid_reg <= 1'b0;
    end else begin
      if (alloc_fire)  tail_reg <= tail_reg + ptr_t'(1);
      if (commit_fire) head_reg <= head_reg + ptr_t'(1);
      count_reg        <= count_reg + (ADDR_WIDTH+1)'(alloc_fire)
                                    - (ADDR_WIDTH+1)'(commit_fire);
      commit_valid_reg <= commit_fire;
      if (commit_fire) begin
        commit_dest_reg <= dest_arr[head_reg];
        commit_data_reg <= commit_data_next;
      end
    end
  end

  assign bus.alloc_ready  = alloc_ready;
  assign bus.alloc_tag    = tail_reg;
  assign bus.commit_valid = commit_valid_reg;
  assign bus.commit_dest  = commit_dest_reg;
  assign bus.commit_data  = commit_data_reg;
  assign bus.count        = count_reg;
endmodule
